de_pipe_reg: RTL and testbench
==============================

Name: de_pipe_reg

Overview:
- Decode-to-Execute pipeline register of the 5-stage MIPS core. It sits directly upstream of the E-stage multiply/divide unit and ALU.
- Captures D-stage operands, control and exception state every cycle. Inserts bubbles on stall or flush, and redirects on interrupt/exception request.
- Guarantees that the MDU start strobe it drives is a single-cycle pulse per instruction.

Parameters:
- RESET_PC, 32'h0000_3000, e_pc value after reset.
- HANDLER_PC, 32'h0000_4180, e_pc value loaded on req.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req  in  1  exception/interrupt request from CP0; flushes this stage
- stall  in  1  hazard stall; D holds, E gets a bubble
- flush  in  1  control flush (eret); E gets a bubble
- d_pc  in  32  D-stage PC
- d_instr  in  32  D-stage instruction word
- d_rs_val  in  32  forwarded rs operand
- d_rt_val  in  32  forwarded rt operand
- d_imm32  in  32  extended immediate
- d_exccode  in  5  exception code raised in F/D (0 = none)
- d_bd  in  1  instruction is in a branch delay slot
- d_mdu_start  in  1  decoded mult/multu/div/divu
- d_mdu_op  in  3  decoded MDU operation (0 = none)
- e_pc, e_instr, e_rs_val, e_rt_val, e_imm32  out  32 each  registered copies
- e_exccode  out  5  registered exception code
- e_bd  out  1  registered delay-slot flag
- e_mdu_start  out  1  MDU start pulse
- e_mdu_op  out  3  MDU operation
- e_valid  out  1  E holds a real instruction (not a bubble)
- bubble_cnt  out  32  bubble counter (see Optional Feature)

Behaviour:
- All outputs are registered and update on the posedge clk only. Latency is 1 cycle from D inputs to E outputs.
- Priority per cycle: reset > req > stall > flush > load.
- reset:
  - e_pc=RESET_PC.
  - All other outputs = 0, including e_valid=0, e_mdu_start=0, e_mdu_op=0 and bubble_cnt=0.
- req:
  - e_pc=HANDLER_PC, e_bd=0.
  - instr, rs, rt, imm, exccode, mdu_start, mdu_op and valid are cleared to 0.
  - req overrides a simultaneous stall or flush.
- stall (bubble):
  - e_pc<=d_pc and e_bd<=d_bd are kept so that CP0 EPC/BD of a later macro-op stay correct.
  - All other fields are cleared, e_valid=0.
- flush without stall:
  - Same as stall, but e_bd<=0.
  - stall and flush together is treated as stall.
- load:
  - Every field copies its d_ input and e_valid<=1.
  - e_mdu_op<=d_mdu_op.
  - e_mdu_start<=d_mdu_start && (d_exccode==0). An excepting instruction never starts the MDU.
- Single-pulse rule:
  - A mult/div held in D by k stall cycles produces k bubbles.
  - It then yields exactly one cycle of e_mdu_start=1, on the cycle after stall drops.
  - Two back-to-back MDU instructions give two pulses on consecutive cycles. Throttling these is the hazard unit's job via MDU Busy.
- A req arriving in the same cycle an MDU instruction would load suppresses e_mdu_start, so no MDU operation begins.
- Width rules: pure pass-through; no arithmetic except bubble_cnt.

Optional Feature:
- Macro: DE_BUBBLE_CNT_EN.
- Defined:
  - bubble_cnt increments by 1 on each cycle where stall or flush causes a bubble and neither reset nor req is active.
  - It wraps from 32'hFFFF_FFFF to 0. Reset clears it.
- Not defined: bubble_cnt is a constant 0 and no counter logic is generated.

Test Plan:
- Reset: assert reset for 2 cycles -> e_pc=32'h0000_3000; e_valid=0; e_mdu_start=0; all other outputs 0.
- Normal load:
  - Stimulus: d_pc=32'h0000_3004, d_instr=32'h0109_0018 (mult), d_mdu_start=1, d_mdu_op=1, stall=0.
  - Response next cycle: e_mdu_start=1, e_mdu_op=1, e_valid=1, e_pc=32'h0000_3004.
  - Response the following cycle, with new non-MDU D inputs: e_mdu_start=0.
- Stall 3 cycles with the same mult in D:
  - During the stall: e_valid=0, e_mdu_start=0, e_pc=32'h0000_3004.
  - After stall drops: exactly one cycle of e_mdu_start=1.
  - With DE_BUBBLE_CNT_EN: bubble_cnt=3.
- req together with stall=1 and d_mdu_start=1 -> e_pc=32'h0000_4180, e_bd=0, e_mdu_start=0, e_valid=0, and bubble_cnt does not increment.
- Flush: flush=1 with d_bd=1 -> e_bd=0, e_valid=0; stall=1 together with flush=1 -> e_bd=1.
- Excepting MDU instruction: d_exccode=5'd10 (RI) with d_mdu_start=1 -> e_exccode=10, e_mdu_start=0, e_valid=1.

Source files
------------

// File: rtl/de_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : de_pipe_reg
//  Purpose  : Decode-to-Execute pipeline register. Captures D-stage operands,
//             control and exception state each cycle. Inserts bubbles on
//             stall/flush and redirects E to the handler PC on req.
//             Per-cycle priority: reset > req > stall > flush > load.
//  Options  : DE_BUBBLE_CNT_EN - when defined, bubble_cnt counts bubbles
//             caused by stall/flush. When undefined it is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module de_pipe_reg #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] d_pc,
   input  logic [31:0] d_instr,
   input  logic [31:0] d_rs_val,
   input  logic [31:0] d_rt_val,
   input  logic [31:0] d_imm32,
   input  logic [4:0]  d_exccode,
   input  logic        d_bd,
   input  logic        d_mdu_start,
   input  logic [2:0]  d_mdu_op,
   output logic [31:0] e_pc,
   output logic [31:0] e_instr,
   output logic [31:0] e_rs_val,
   output logic [31:0] e_rt_val,
   output logic [31:0] e_imm32,
   output logic [4:0]  e_exccode,
   output logic        e_bd,
   output logic        e_mdu_start,
   output logic [2:0]  e_mdu_op,
   output logic        e_valid,
   output logic [31:0] bubble_cnt
);

   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_rs_val;
   logic [31:0] r_rt_val;
   logic [31:0] r_imm32;
   logic [4:0]  r_exccode;
   logic        r_bd;
   logic        r_mdu_start;
   logic [2:0]  r_mdu_op;
   logic        r_valid;

   // A bubble is inserted by stall or flush whenever reset and req are idle.
   logic w_bubble;
   // An excepting instruction must never start the MDU.
   logic w_mdu_go;

   assign w_bubble = ~reset & ~req & (stall | flush);
   assign w_mdu_go = d_mdu_start & (d_exccode == 5'd0);

   // E-stage register: reset, redirect, bubble or load, in priority order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc        <= RESET_PC;
         r_instr     <= 32'd0;
         r_rs_val    <= 32'd0;
         r_rt_val    <= 32'd0;
         r_imm32     <= 32'd0;
         r_exccode   <= 5'd0;
         r_bd        <= 1'b0;
         r_mdu_start <= 1'b0;
         r_mdu_op    <= 3'd0;
         r_valid     <= 1'b0;
      end else if (req) begin
         r_pc        <= HANDLER_PC;
         r_instr     <= 32'd0;
         r_rs_val    <= 32'd0;
         r_rt_val    <= 32'd0;
         r_imm32     <= 32'd0;
         r_exccode   <= 5'd0;
         r_bd        <= 1'b0;
         r_mdu_start <= 1'b0;
         r_mdu_op    <= 3'd0;
         r_valid     <= 1'b0;
      end else if (stall || flush) begin
         // PC (and BD on a stall) survive the bubble so a later exception
         // still reports the right EPC/BD; stall wins over flush for BD.
         r_pc        <= d_pc;
         r_bd        <= stall ? d_bd : 1'b0;
         r_instr     <= 32'd0;
         r_rs_val    <= 32'd0;
         r_rt_val    <= 32'd0;
         r_imm32     <= 32'd0;
         r_exccode   <= 5'd0;
         r_mdu_start <= 1'b0;
         r_mdu_op    <= 3'd0;
         r_valid     <= 1'b0;
      end else begin
         // A stalled MDU op only reaches this branch once, so the start
         // strobe is a single pulse per instruction.
         r_pc        <= d_pc;
         r_instr     <= d_instr;
         r_rs_val    <= d_rs_val;
         r_rt_val    <= d_rt_val;
         r_imm32     <= d_imm32;
         r_exccode   <= d_exccode;
         r_bd        <= d_bd;
         r_mdu_start <= w_mdu_go;
         r_mdu_op    <= d_mdu_op;
         r_valid     <= 1'b1;
      end
   end

   assign e_pc        = r_pc;
   assign e_instr     = r_instr;
   assign e_rs_val    = r_rs_val;
   assign e_rt_val    = r_rt_val;
   assign e_imm32     = r_imm32;
   assign e_exccode   = r_exccode;
   assign e_bd        = r_bd;
   assign e_mdu_start = r_mdu_start;
   assign e_mdu_op    = r_mdu_op;
   assign e_valid     = r_valid;

`ifdef DE_BUBBLE_CNT_EN
   logic [31:0] r_bubble_cnt;

   // Free-running bubble counter; wraps naturally at 32 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bubble_cnt <= 32'd0;
      end else if (w_bubble) begin
         r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
   end

   assign bubble_cnt = r_bubble_cnt;
`else
   assign bubble_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_de_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_de_pipe_reg
//  Purpose  : Scoreboard bench for de_pipe_reg. A driver issues one stimulus
//             per cycle (directed sequence, then random) and pushes the
//             reference-model response; a monitor pops and compares after
//             every clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_de_pipe_reg;

   localparam logic [31:0] RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
   localparam int          N_RANDOM   = 400;

   typedef struct {
      logic        reset;
      logic        req;
      logic        stall;
      logic        flush;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] imm;
      logic [4:0]  exccode;
      logic        bd;
      logic        mdu_start;
      logic [2:0]  mdu_op;
   } stim_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] imm;
      logic [4:0]  exccode;
      logic        bd;
      logic        mdu_start;
      logic [2:0]  mdu_op;
      logic        valid;
      logic [31:0] bcnt;
      string       tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, req, stall, flush;
   logic [31:0] d_pc, d_instr, d_rs_val, d_rt_val, d_imm32;
   logic [4:0]  d_exccode;
   logic        d_bd, d_mdu_start;
   logic [2:0]  d_mdu_op;
   logic [31:0] e_pc, e_instr, e_rs_val, e_rt_val, e_imm32;
   logic [4:0]  e_exccode;
   logic        e_bd, e_mdu_start, e_valid;
   logic [2:0]  e_mdu_op;
   logic [31:0] bubble_cnt;

   int   n_assert = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];
   longint m_bubbles = 0;   // bubbles since last reset, per the rules

   always #5 clk = ~clk;

   de_pipe_reg #(.RESET_PC(RESET_PC), .HANDLER_PC(HANDLER_PC)) dut (
      .clk(clk), .reset(reset), .req(req), .stall(stall), .flush(flush),
      .d_pc(d_pc), .d_instr(d_instr), .d_rs_val(d_rs_val), .d_rt_val(d_rt_val),
      .d_imm32(d_imm32), .d_exccode(d_exccode), .d_bd(d_bd),
      .d_mdu_start(d_mdu_start), .d_mdu_op(d_mdu_op),
      .e_pc(e_pc), .e_instr(e_instr), .e_rs_val(e_rs_val), .e_rt_val(e_rt_val),
      .e_imm32(e_imm32), .e_exccode(e_exccode), .e_bd(e_bd),
      .e_mdu_start(e_mdu_start), .e_mdu_op(e_mdu_op), .e_valid(e_valid),
      .bubble_cnt(bubble_cnt)
   );

   // Reference model: what E must hold after a clock edge with stimulus s.
   function automatic exp_t model(stim_t s, string tag);
      exp_t e;
      e.pc = 32'd0; e.instr = 32'd0; e.rs = 32'd0; e.rt = 32'd0; e.imm = 32'd0;
      e.exccode = 5'd0; e.bd = 1'b0; e.mdu_start = 1'b0; e.mdu_op = 3'd0;
      e.valid = 1'b0; e.tag = tag;
      if (s.reset) begin
         e.pc = RESET_PC;
         m_bubbles = 0;
      end else if (s.req) begin
         e.pc = HANDLER_PC;
      end else if (s.stall || s.flush) begin
         e.pc = s.pc;
         e.bd = s.stall ? s.bd : 1'b0;
         m_bubbles = m_bubbles + 1;
      end else begin
         e.pc = s.pc; e.instr = s.instr; e.rs = s.rs; e.rt = s.rt; e.imm = s.imm;
         e.exccode = s.exccode; e.bd = s.bd; e.mdu_op = s.mdu_op; e.valid = 1'b1;
         e.mdu_start = s.mdu_start && (s.exccode == 5'd0);
      end
`ifdef DE_BUBBLE_CNT_EN
      e.bcnt = 32'(m_bubbles % 64'h1_0000_0000);
`else
      e.bcnt = 32'd0;
`endif
      return e;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s.reset = 0; s.req = 0; s.stall = 0; s.flush = 0;
      s.pc = 32'h0000_3000; s.instr = 32'h0109_5020; s.rs = 32'h11; s.rt = 32'h22;
      s.imm = 32'h33; s.exccode = 5'd0; s.bd = 0; s.mdu_start = 0; s.mdu_op = 3'd0;
      return s;
   endfunction

   function automatic stim_t mult_at(logic [31:0] pc);
      stim_t s = idle();
      s.pc = pc; s.instr = 32'h0109_0018; s.mdu_start = 1; s.mdu_op = 3'd1;
      s.rs = 32'hDEAD_0001; s.rt = 32'hBEEF_0002;
      return s;
   endfunction

   // Drive one stimulus mid-cycle and queue the expected response.
   task automatic issue(stim_t s, string tag);
      @(negedge clk);
      reset = s.reset; req = s.req; stall = s.stall; flush = s.flush;
      d_pc = s.pc; d_instr = s.instr; d_rs_val = s.rs; d_rt_val = s.rt;
      d_imm32 = s.imm; d_exccode = s.exccode; d_bd = s.bd;
      d_mdu_start = s.mdu_start; d_mdu_op = s.mdu_op;
      exp_q.push_back(model(s, tag));
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: after each edge, compare E against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.tag, " e_pc"},        e_pc, e.pc);
            chk({e.tag, " e_instr"},     e_instr, e.instr);
            chk({e.tag, " e_rs_val"},    e_rs_val, e.rs);
            chk({e.tag, " e_rt_val"},    e_rt_val, e.rt);
            chk({e.tag, " e_imm32"},     e_imm32, e.imm);
            chk({e.tag, " e_exccode"},   {27'd0, e_exccode}, {27'd0, e.exccode});
            chk({e.tag, " e_bd"},        {31'd0, e_bd}, {31'd0, e.bd});
            chk({e.tag, " e_mdu_start"}, {31'd0, e_mdu_start}, {31'd0, e.mdu_start});
            chk({e.tag, " e_mdu_op"},    {29'd0, e_mdu_op}, {29'd0, e.mdu_op});
            chk({e.tag, " e_valid"},     {31'd0, e_valid}, {31'd0, e.valid});
            chk({e.tag, " bubble_cnt"},  bubble_cnt, e.bcnt);
         end
      end
   end

   // Driver: directed test-plan sequence, then randomized traffic.
   initial begin
      stim_t s;
      int    pulses;
      reset = 1; req = 0; stall = 0; flush = 0;
      d_pc = 0; d_instr = 0; d_rs_val = 0; d_rt_val = 0; d_imm32 = 0;
      d_exccode = 0; d_bd = 0; d_mdu_start = 0; d_mdu_op = 0;

      s = idle(); s.reset = 1;
      issue(s, "reset0");
      issue(s, "reset1");

      issue(mult_at(32'h0000_3004), "load_mult");
      s = idle(); s.pc = 32'h0000_3008;
      issue(s, "load_nonmdu");

      // mult held in D for three stall cycles, then released
      s = mult_at(32'h0000_3004); s.stall = 1;
      for (int i = 0; i < 3; i++) issue(s, "stall_mult");
      issue(mult_at(32'h0000_3004), "stall_release");
      s = idle(); s.pc = 32'h0000_3008;
      issue(s, "after_release");

      // single-pulse rule, checked directly on the waveform
      pulses = 0;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               @(posedge clk); #2;
               if (e_mdu_start) pulses++;
            end
         end
         begin
            s = mult_at(32'h0000_3010); s.stall = 1;
            issue(s, "pulse_stall");
            issue(s, "pulse_stall");
            issue(mult_at(32'h0000_3010), "pulse_go");
            s = idle(); s.pc = 32'h0000_3014;
            issue(s, "pulse_after");
            issue(s, "pulse_after");
            issue(s, "pulse_after");
         end
      join
      chk("single_pulse count", pulses, 32'd1);

      // back-to-back MDU instructions -> two consecutive pulses
      issue(mult_at(32'h0000_3020), "b2b_mult0");
      issue(mult_at(32'h0000_3024), "b2b_mult1");

      // req with stall and a loading MDU op
      s = mult_at(32'h0000_3028); s.req = 1; s.stall = 1; s.bd = 1;
      issue(s, "req_stall_mdu");
      s = mult_at(32'h0000_302C); s.req = 1; s.flush = 1;
      issue(s, "req_flush");

      // flush vs stall+flush with a delay-slot instruction
      s = idle(); s.pc = 32'h0000_3030; s.bd = 1; s.flush = 1;
      issue(s, "flush_bd");
      s.stall = 1;
      issue(s, "stall_flush_bd");

      // excepting MDU instruction (RI)
      s = mult_at(32'h0000_3034); s.exccode = 5'd10;
      issue(s, "exc_mdu");

      // randomized traffic
      for (int i = 0; i < N_RANDOM; i++) begin
         s.reset     = ($urandom_range(0, 49) == 0);
         s.req       = ($urandom_range(0, 9) == 0);
         s.stall     = ($urandom_range(0, 3) == 0);
         s.flush     = ($urandom_range(0, 6) == 0);
         s.pc        = $urandom & 32'hFFFF_FFFC;
         s.instr     = $urandom;
         s.rs        = $urandom;
         s.rt        = $urandom;
         s.imm       = $urandom;
         s.exccode   = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         s.bd        = 1'($urandom_range(0, 1));
         s.mdu_start = 1'($urandom_range(0, 1));
         s.mdu_op    = 3'($urandom_range(0, 7));
         issue(s, "random");
      end

      s = idle();
      issue(s, "drain");
      @(negedge clk);
      @(negedge clk);
      chk("scoreboard drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
